// File: rtl/mux_reply_pack.sv
// Captures one reply burst into a buffer and re-emits it as a framed packet:
// HEAD0, HEAD1, LEN_H, LEN_L, payload, XOR checksum, paced by reply_ready.
module mux_reply_pack #(
  parameter int unsigned AW    = 8,
  parameter logic [7:0]  HEAD0 = 8'hAA,
  parameter logic [7:0]  HEAD1 = 8'h55
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] replay_din,
  input  logic       replay_din_en,
  input  logic       reply_ready,
  output logic [7:0] reply_dout,
  output logic       reply_dout_en,
  output logic       reply_sop,
  output logic       reply_eop,
  output logic       busy,
  output logic       ovf_err,
  output logic       drop_err
);

  localparam int unsigned Depth   = 2 ** AW;
  localparam logic [AW:0] CntFull = (AW + 1)'(1) << AW;
  localparam logic [AW:0] CntOne  = (AW + 1)'(1);

  typedef enum logic [3:0] {
    StIdle, StCapture, StWaitRdy, StHdr0, StHdr1, StLenH, StLenL, StPayload, StCsum
  } state_e;

  state_e        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    dout_q, dout_d;
  logic          dout_en_q, dout_en_d;
  logic          sop_q, sop_d;
  logic          eop_q, eop_d;
  logic          ovf_err_q, ovf_err_d;
  logic          drop_err_q, drop_err_d;
  logic          ovf_seen_q, ovf_seen_d;
  logic          dropping_q, dropping_d;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    rd_data_q;
  logic [15:0]   len;
  logic [7:0]    mem [Depth];

  assign len = 16'(cnt_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_ptr_d   = rd_ptr_q;
    csum_d     = csum_q;
    dout_d     = dout_q;
    dout_en_d  = 1'b0;
    sop_d      = 1'b0;
    eop_d      = 1'b0;
    ovf_err_d  = 1'b0;
    drop_err_d = 1'b0;
    ovf_seen_d = ovf_seen_q;
    dropping_d = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;

    unique case (state_q)
      StIdle: begin
        rd_ptr_d = '0;
        if (replay_din_en) begin
          // Tail of a burst that was dropped while the last packet finished.
          if (dropping_q) begin
            dropping_d = 1'b1;
          end else begin
            wr_en      = 1'b1;
            cnt_d      = CntOne;
            csum_d     = replay_din;
            ovf_seen_d = 1'b0;
            state_d    = StCapture;
          end
        end
      end
      StCapture: begin
        if (replay_din_en) begin
          if (cnt_q != CntFull) begin
            wr_en   = 1'b1;
            wr_addr = cnt_q[AW-1:0];
            cnt_d   = cnt_q + CntOne;
            csum_d  = csum_q ^ replay_din;
          end else if (!ovf_seen_q) begin
            ovf_err_d  = 1'b1;
            ovf_seen_d = 1'b1;
          end
        end else begin
          state_d = StWaitRdy;
        end
      end
      default: begin
        dropping_d = replay_din_en;
        drop_err_d = replay_din_en & ~dropping_q;
        if (reply_ready) begin
          dout_en_d = 1'b1;
          case (state_q)
            StWaitRdy: begin
              dout_d  = HEAD0;
              sop_d   = 1'b1;
              state_d = StHdr0;
            end
            StHdr0: begin
              dout_d  = HEAD1;
              state_d = StHdr1;
            end
            StHdr1: begin
              dout_d  = len[15:8];
              state_d = StLenH;
            end
            StLenH: begin
              dout_d  = len[7:0];
              state_d = StLenL;
            end
            StLenL: begin
              dout_d   = rd_data_q;
              rd_ptr_d = rd_ptr_q + CntOne;
              state_d  = StPayload;
            end
            StPayload: begin
              if (rd_ptr_q == cnt_q) begin
                dout_d  = csum_q;
                eop_d   = 1'b1;
                state_d = StCsum;
              end else begin
                dout_d   = rd_data_q;
                rd_ptr_d = rd_ptr_q + CntOne;
              end
            end
            StCsum: begin
              dout_en_d = 1'b0;
              state_d   = StIdle;
            end
            default: dout_en_d = 1'b0;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      csum_q     <= '0;
      dout_q     <= '0;
      dout_en_q  <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      ovf_err_q  <= 1'b0;
      drop_err_q <= 1'b0;
      ovf_seen_q <= 1'b0;
      dropping_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      csum_q     <= csum_d;
      dout_q     <= dout_d;
      dout_en_q  <= dout_en_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      ovf_err_q  <= ovf_err_d;
      drop_err_q <= drop_err_d;
      ovf_seen_q <= ovf_seen_d;
      dropping_q <= dropping_d;
    end
  end

  // Read port follows the next pointer so the upcoming payload byte is always staged.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= replay_din;
    end
    rd_data_q <= mem[rd_ptr_d[AW-1:0]];
  end

  assign reply_dout    = dout_q;
  assign reply_dout_en = dout_en_q;
  assign reply_sop     = sop_q;
  assign reply_eop     = eop_q;
  assign busy          = (state_q != StIdle);
  assign ovf_err       = ovf_err_q;
  assign drop_err      = drop_err_q;

endmodule

// File: tb/tb_mux_reply_pack.sv
// Scoreboard bench for mux_reply_pack: expected frames are queued as bursts are
// driven and popped by a monitor whenever the DUT presents a byte.
module tb_mux_reply_pack;

  localparam int unsigned AW = 4;
  localparam int unsigned MaxPl = 2 ** AW;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] replay_din;
  logic       replay_din_en;
  logic       reply_ready;
  logic [7:0] reply_dout;
  logic       reply_dout_en;
  logic       reply_sop;
  logic       reply_eop;
  logic       busy;
  logic       ovf_err;
  logic       drop_err;

  int checks = 0;
  int errors = 0;
  int pop_cnt = 0;
  int drop_cnt = 0;
  int ovf_cnt = 0;
  int ovf_cyc = -1;
  int cyc = 0;
  logic rdy_s = 1'b0;
  logic [9:0] mon_e;
  logic [9:0] exp_q[$];
  logic [7:0] pl_q[$];

  mux_reply_pack #(.AW(AW), .HEAD0(8'hAA), .HEAD1(8'h55)) dut (
    .clk           (clk),
    .rst           (rst),
    .replay_din    (replay_din),
    .replay_din_en (replay_din_en),
    .reply_ready   (reply_ready),
    .reply_dout    (reply_dout),
    .reply_dout_en (reply_dout_en),
    .reply_sop     (reply_sop),
    .reply_eop     (reply_eop),
    .busy          (busy),
    .ovf_err       (ovf_err),
    .drop_err      (drop_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rdy_s <= reply_ready;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (drop_err) drop_cnt++;
      if (ovf_err) begin
        ovf_cnt++;
        ovf_cyc = cyc;
      end
      if (reply_dout_en) begin
        checks++;
        if (!rdy_s) begin
          errors++;
          $display("FAIL ready_gate: dout_en=1 got, required 0 (ready low on prior edge)");
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got %02h sop=%b eop=%b, required no output",
                   reply_dout, reply_sop, reply_eop);
        end else begin
          mon_e = exp_q.pop_front();
          if ({reply_sop, reply_eop, reply_dout} !== mon_e) begin
            errors++;
            $display("FAIL frame_byte: got sop=%b eop=%b %02h, required sop=%b eop=%b %02h",
                     reply_sop, reply_eop, reply_dout, mon_e[9], mon_e[8], mon_e[7:0]);
          end
        end
        pop_cnt++;
      end
    end
  end

  // Reference framing of pl_q, truncated to the buffer size.
  task automatic push_expected();
    int n;
    logic [7:0] cs;
    n  = (pl_q.size() > MaxPl) ? MaxPl : pl_q.size();
    cs = 8'h00;
    exp_q.push_back({2'b10, 8'hAA});
    exp_q.push_back({2'b00, 8'h55});
    exp_q.push_back({2'b00, 8'(n >> 8)});
    exp_q.push_back({2'b00, 8'(n & 255)});
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({2'b00, pl_q[i]});
      cs ^= pl_q[i];
    end
    exp_q.push_back({2'b01, cs});
  endtask

  task automatic send_burst();
    foreach (pl_q[i]) begin
      @(posedge clk); #1;
      replay_din    = pl_q[i];
      replay_din_en = 1'b1;
    end
    @(posedge clk); #1;
    replay_din_en = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) break;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d bytes outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    replay_din = 8'h00;
    replay_din_en = 1'b0;
    reply_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({reply_dout, reply_dout_en, reply_sop, reply_eop, busy, ovf_err, drop_err} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %02h %b%b%b%b%b%b, required all 0", reply_dout,
               reply_dout_en, reply_sop, reply_eop, busy, ovf_err, drop_err);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || reply_dout_en !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b en=%b, required 0 0", busy, reply_dout_en);
    end
  endtask

  task automatic test_basic();
    int n = 0, first = -1, last = -1, eop_c = -100;
    logic eop_busy = 1'b0, after_busy = 1'b1;
    reply_ready = 1'b1;
    pl_q = '{8'h01, 8'h02, 8'h03};
    push_expected();
    send_burst();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); #1;
      if (c == eop_c + 1) after_busy = busy;
      if (reply_dout_en) begin
        if (first < 0) first = c;
        last = c;
        n++;
        if (reply_eop) begin
          eop_c    = c;
          eop_busy = busy;
        end
      end
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL basic_count: got %0d bytes, required 8", n);
    end
    checks++;
    if (last - first != 7) begin
      errors++;
      $display("FAIL basic_contiguous: got span %0d, required 7", last - first);
    end
    checks++;
    if (eop_busy !== 1'b1 || after_busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: got busy@eop=%b after=%b, required 1 0", eop_busy, after_busy);
    end
    wait_drain("basic", 5);
  endtask

  task automatic test_ready_toggle();
    reply_ready = 1'b0;
    pl_q = '{8'h01, 8'h02, 8'h03};
    push_expected();
    send_burst();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
      reply_ready = ~reply_ready;
    end
    wait_drain("toggle", 5);
    reply_ready = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_overflow();
    int c0 = 0;
    int o0 = ovf_cnt;
    reply_ready = 1'b0;
    pl_q.delete();
    for (int i = 0; i < 20; i++) pl_q.push_back(8'(i));
    push_expected();
    foreach (pl_q[i]) begin
      @(posedge clk); #1;
      if (i == 0) c0 = cyc;
      replay_din    = pl_q[i];
      replay_din_en = 1'b1;
    end
    @(posedge clk); #1;
    replay_din_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ovf_cnt - o0 != 1) begin
      errors++;
      $display("FAIL ovf_pulses: got %0d, required 1", ovf_cnt - o0);
    end
    checks++;
    if (ovf_cyc != c0 + 17) begin
      errors++;
      $display("FAIL ovf_position: got cycle %0d, required %0d", ovf_cyc, c0 + 17);
    end
    reply_ready = 1'b1;
    wait_drain("ovf", 40);
  endtask

  task automatic test_drop();
    int d0 = drop_cnt;
    bit seen = 0;
    reply_ready = 1'b1;
    pl_q = '{8'h11, 8'h22, 8'h33};
    push_expected();
    send_burst();
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk); #1;
      seen = reply_sop;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL drop_sop_timeout: got no sop, required sop within 10 cycles");
    end
    pl_q = '{8'h77, 8'h88};
    send_burst();
    wait_drain("drop", 20);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (drop_cnt - d0 != 1) begin
      errors++;
      $display("FAIL drop_pulses: got %0d, required 1", drop_cnt - d0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_no_second: got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_rst_mid();
    int p0 = pop_cnt;
    reply_ready = 1'b1;
    pl_q = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    push_expected();
    send_burst();
    for (int i = 0; i < 30 && pop_cnt < p0 + 6; i++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({reply_dout, reply_dout_en, reply_sop, reply_eop, busy} !== 12'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got %02h en=%b sop=%b eop=%b busy=%b, required all 0",
               reply_dout, reply_dout_en, reply_sop, reply_eop, busy);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    pl_q = '{8'hFF};
    push_expected();
    send_burst();
    wait_drain("rst_mid", 20);
  endtask

  task automatic test_back_to_back();
    int d0 = drop_cnt;
    bit seen = 0;
    reply_ready = 1'b1;
    pl_q = '{8'hA5};
    push_expected();
    send_burst();
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); #1;
      seen = reply_eop;
    end
    @(posedge clk); #1;
    checks++;
    if (!seen || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_busy_fall: got eop_seen=%b busy=%b, required 1 0", seen, busy);
    end
    push_expected();
    replay_din    = 8'hA5;
    replay_din_en = 1'b1;
    @(posedge clk); #1;
    replay_din_en = 1'b0;
    wait_drain("b2b", 20);
    checks++;
    if (drop_cnt != d0) begin
      errors++;
      $display("FAIL b2b_no_drop: got %0d drops, required 0", drop_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ready_toggle();
    test_overflow();
    test_drop();
    test_rst_mid();
    test_back_to_back();
    repeat (10) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
